// File: rtl/bsg_ready_to_credit_flow_converter_rr_pkg.sv
// Width helpers for the multi-channel ready-to-credit converter.
// Counters and the top both derive their widths from the same parameters.
package bsg_ready_to_credit_flow_converter_rr_pkg;

   function automatic int cnt_width(input int max_val);
      return $clog2(max_val + 1);
   endfunction

   function automatic int step_width(input int max_step);
      return $clog2(max_step + 1);
   endfunction

   // A single channel still needs a one-bit id port.
   function automatic int id_width(input int els);
      return (els > 1) ? $clog2(els) : 1;
   endfunction

endpackage

// File: rtl/bsg_counter_up_down_variable_sat.sv
// Saturating credit counter: down by one per send, up by a variable amount per return.
// overflow_o flags a cycle whose next value would exceed max_val_p.
module bsg_counter_up_down_variable_sat
   import bsg_ready_to_credit_flow_converter_rr_pkg::*;
#(
   parameter int max_val_p  = 150,
   parameter int init_val_p = 1,
   parameter int max_step_p = 1
) (
   input  logic                                 clk_i,
   input  logic                                 reset_i,
   input  logic [step_width(max_step_p)-1:0]    up_i,
   input  logic                                 down_i,
   output logic [cnt_width(max_val_p)-1:0]      count_o,
   output logic                                 overflow_o
);

   localparam int cnt_w  = cnt_width(max_val_p);
   localparam int step_w = step_width(max_step_p);
   localparam logic signed [cnt_w+1:0] max_s = (cnt_w+2)'(max_val_p);

   logic [cnt_w-1:0]        count_r;
   logic signed [cnt_w+1:0] next_s;

   // Two spare bits keep both the sum of a full counter plus a return and
   // the (unreachable) decrement below zero representable.
   assign next_s = $signed({2'b00, count_r})
                 + $signed({{(cnt_w+2-step_w){1'b0}}, up_i})
                 - $signed({{(cnt_w+1){1'b0}}, down_i});

   assign overflow_o = (next_s > max_s);
   assign count_o    = count_r;

   always_ff @(posedge clk_i) begin
      if (reset_i)
         count_r <= cnt_w'(init_val_p);
      else if (overflow_o)
         count_r <= cnt_w'(max_val_p);
      else
         count_r <= next_s[cnt_w-1:0];
   end

   always @(posedge clk_i) begin
      if (!reset_i)
         assert (up_i <= step_w'(max_step_p))
            else $error("credit return %0d exceeds step limit %0d", up_i, max_step_p);
   end

endmodule

// File: rtl/bsg_ready_to_credit_flow_converter_rr.sv
// Round-robin arbitration of valid/ready channels onto one credit-based link.
// Each channel keeps its own saturating credit counter; overflow sets a sticky error.
module bsg_ready_to_credit_flow_converter_rr
   import bsg_ready_to_credit_flow_converter_rr_pkg::*;
#(
   parameter int els_p            = 4,
   parameter int credit_initial_p = 1,
   parameter int credit_max_val_p = 150,
   parameter int credit_step_p    = 1
) (
   input  logic                                        clk_i,
   input  logic                                        reset_i,
   input  logic [els_p-1:0]                            v_i,
   output logic [els_p-1:0]                            yumi_o,
   output logic [els_p-1:0]                            credit_avail_o,
   output logic                                        v_o,
   output logic [id_width(els_p)-1:0]                  ch_id_o,
   input  logic [els_p*step_width(credit_step_p)-1:0]  credit_i,
   output logic                                        error_o
);

   localparam int cnt_w  = cnt_width(credit_max_val_p);
   localparam int step_w = step_width(credit_step_p);
   localparam int id_w   = id_width(els_p);

   logic [cnt_w-1:0] count [els_p];
   logic [els_p-1:0] overflow;
   logic [els_p-1:0] req;
   logic [id_w-1:0]  ptr_r, ptr_n;
   logic             error_r;

   for (genvar i = 0; i < els_p; i++) begin : g_ch
      bsg_counter_up_down_variable_sat #(
         .max_val_p  (credit_max_val_p),
         .init_val_p (credit_initial_p),
         .max_step_p (credit_step_p)
      ) u_cnt (
         .clk_i      (clk_i),
         .reset_i    (reset_i),
         .up_i       (credit_i[i*step_w +: step_w]),
         .down_i     (yumi_o[i]),
         .count_o    (count[i]),
         .overflow_o (overflow[i])
      );
      assign credit_avail_o[i] = (count[i] != '0);
   end

   assign req = reset_i ? '0 : (v_i & credit_avail_o);

   // Scan upward from the pointer, wrapping; the first request wins.
   always_comb begin
      int idx;
      idx     = 0;
      yumi_o  = '0;
      ch_id_o = '0;
      v_o     = 1'b0;
      for (int k = 0; k < els_p; k++) begin
         idx = int'(ptr_r) + k;
         if (idx >= els_p)
            idx = idx - els_p;
         if (!v_o && req[idx]) begin
            yumi_o[idx] = 1'b1;
            ch_id_o     = id_w'(idx);
            v_o         = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_n = ptr_r;
      if (v_o)
         ptr_n = (ch_id_o == id_w'(els_p-1)) ? '0 : ch_id_o + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ptr_r   <= '0;
         error_r <= 1'b0;
      end else begin
         ptr_r   <= ptr_n;
         error_r <= error_r | (|overflow);
      end
   end

   assign error_o = error_r;

endmodule

// File: tb/tb_bsg_ready_to_credit_flow_converter_rr.sv
// Self-checking bench: directed scenarios plus constrained-random traffic,
// all checked against a per-channel credit/round-robin reference model.
module tb_bsg_ready_to_credit_flow_converter_rr;

   localparam int els   = 4;
   localparam int init  = 1;
   localparam int maxv  = 150;
   localparam int stepv = 3;
   localparam int sw    = 2;

   logic            clk_i = 1'b0;
   logic            reset_i = 1'b1;
   logic [els-1:0]  v_i = '0;
   logic [els-1:0]  yumi_o;
   logic [els-1:0]  credit_avail_o;
   logic            v_o;
   logic [1:0]      ch_id_o;
   logic [els*sw-1:0] credit_i = '0;
   logic            error_o;

   bsg_ready_to_credit_flow_converter_rr #(
      .els_p            (els),
      .credit_initial_p (init),
      .credit_max_val_p (maxv),
      .credit_step_p    (stepv)
   ) dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .v_i            (v_i),
      .yumi_o         (yumi_o),
      .credit_avail_o (credit_avail_o),
      .v_o            (v_o),
      .ch_id_o        (ch_id_o),
      .credit_i       (credit_i),
      .error_o        (error_o)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_bad = 0;

   // reference state: plain integer credit counts, next-to-serve index, sticky flag
   int       m_cnt [els];
   int       m_ptr = 0;
   bit       m_err = 1'b0;
   bit       m_valid = 1'b0;
   logic [els-1:0] exp_y;
   int       exp_id;
   bit       cur_rst;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drive inputs, predict this cycle's combinational outputs and compare.
   task automatic apply(input logic [els-1:0] v, input logic [els*sw-1:0] cr, input bit rst);
      v_i = v; credit_i = cr; reset_i = rst; cur_rst = rst;
      #1;
      exp_y = '0; exp_id = 0;
      if (!rst) begin
         for (int k = 0; k < els; k++) begin
            int c;
            c = (m_ptr + k) % els;
            if (exp_y == '0 && v[c] && m_cnt[c] > 0) begin
               exp_y[c] = 1'b1;
               exp_id = c;
            end
         end
      end
      chk("yumi", 32'(yumi_o), 32'(exp_y));
      chk("v_o", 32'(v_o), 32'(exp_y != '0));
      chk("ch_id", 32'(ch_id_o), 32'(exp_id));
      if (m_valid) begin
         logic [els-1:0] av;
         for (int i = 0; i < els; i++) av[i] = (m_cnt[i] != 0);
         chk("avail", 32'(credit_avail_o), 32'(av));
         chk("error", 32'(error_o), 32'(m_err));
      end
   endtask

   // Advance one clock and update the reference state.
   task automatic adv();
      @(posedge clk_i);
      if (cur_rst) begin
         for (int i = 0; i < els; i++) m_cnt[i] = init;
         m_ptr = 0; m_err = 1'b0; m_valid = 1'b1;
      end else begin
         for (int i = 0; i < els; i++) begin
            int n;
            n = m_cnt[i] - int'(exp_y[i]) + int'(credit_i[i*sw +: sw]);
            if (n > maxv) begin
               m_cnt[i] = maxv; m_err = 1'b1;
            end else m_cnt[i] = n;
         end
         if (exp_y != '0) m_ptr = (exp_id + 1) % els;
      end
      #2;
   endtask

   task automatic tick(input logic [els-1:0] v, input logic [els*sw-1:0] cr, input bit rst);
      apply(v, cr, rst);
      adv();
   endtask

   initial begin
      logic [els-1:0] vr;
      logic [els*sw-1:0] cr;
      @(posedge clk_i); #2;
      tick('0, '0, 1'b1);
      tick(4'hF, 8'hFF, 1'b1);

      // reset values, then one grant per channel in order
      apply('0, '0, 1'b0);
      chk("rst_avail", 32'(credit_avail_o), 32'hF);
      chk("rst_error", 32'(error_o), 32'h0);
      adv();
      for (int k = 0; k < els; k++) begin
         apply(4'hF, '0, 1'b0);
         chk("order_id", 32'(ch_id_o), 32'(k));
         adv();
      end
      apply(4'hF, '0, 1'b0);
      chk("drained_avail", 32'(credit_avail_o), 32'h0);
      chk("drained_v", 32'(v_o), 32'h0);
      adv();

      // fairness between channels 1 and 3, then 1 alone
      repeat (20) tick('0, 8'hFF, 1'b0);
      for (int k = 0; k < 4; k++) begin
         apply(4'b1010, '0, 1'b0);
         chk("fair_id", 32'(ch_id_o), (k % 2 == 0) ? 32'd1 : 32'd3);
         adv();
      end
      for (int k = 0; k < 3; k++) begin
         apply(4'b0010, '0, 1'b0);
         chk("solo_yumi", 32'(yumi_o), 32'b0010);
         adv();
      end

      // exhaust channel 2, refill one credit, no same-cycle bypass
      repeat (60) tick(4'b0100, '0, 1'b0);
      apply(4'b0100, '0, 1'b0);
      chk("empty_yumi", 32'(yumi_o), 32'h0);
      adv();
      apply(4'b0100, 8'h10, 1'b0);
      chk("nobypass_yumi", 32'(yumi_o), 32'h0);
      adv();
      apply(4'b0100, '0, 1'b0);
      chk("refill_yumi", 32'(yumi_o), 32'b0100);
      adv();
      apply(4'b0100, '0, 1'b0);
      chk("reempty_yumi", 32'(yumi_o), 32'h0);
      adv();

      // simultaneous send and return
      repeat (3) tick(4'b1000, 8'hC0, 1'b0);
      tick(4'b0001, 8'h01, 1'b0);

      // saturate every channel; error is sticky
      repeat (50) tick('0, 8'hFF, 1'b0);
      repeat (3) begin
         apply('0, '0, 1'b0);
         chk("sticky_err", 32'(error_o), 32'h1);
         adv();
      end

      // reset during traffic
      tick(4'hF, '0, 1'b0);
      apply(4'hF, 8'hFF, 1'b1);
      chk("midrst_v", 32'(v_o), 32'h0);
      adv();
      apply(4'hF, '0, 1'b0);
      chk("postrst_id", 32'(ch_id_o), 32'h0);
      chk("postrst_err", 32'(error_o), 32'h0);
      adv();

      // random traffic, valid held until accepted
      vr = '0;
      for (int t = 0; t < 400; t++) begin
         for (int i = 0; i < els; i++) begin
            if (!(vr[i] && !exp_y[i])) vr[i] = 1'($urandom_range(0, 1));
            cr[i*sw +: sw] = ($urandom_range(0, 5) > 3) ? 2'($urandom_range(1, 3)) : 2'd0;
         end
         tick(vr, cr, ($urandom_range(0, 59) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
